// File: rtl/fifo_bit_serializer.sv
// Pops bytes from an 8-bit FIFO and shifts them out one bit at a time over a valid/ready
// handshake. start launches a frame of tx_len bytes, and done pulses after the last bit is accepted.
module fifo_bit_serializer #(
   parameter int DATA_W       = 8,
   parameter int LEN_W        = 6,
   parameter int FETCH_CYCLES = 2,
   parameter bit MSB_FIRST    = 1'b1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [LEN_W-1:0]  tx_len,
   input  logic              abort,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_data,
   output logic              fifo_read_en,
   output logic              bit_out,
   output logic              bit_valid,
   input  logic              bit_ready,
   output logic              busy,
   output logic              underrun,
   output logic              done,
   output logic [LEN_W-1:0]  bytes_left
);

   localparam int BC_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam int FC_W = $clog2(FETCH_CYCLES) + 1;
   localparam logic [BC_W-1:0] BIT_LAST   = BC_W'(DATA_W - 1);
   localparam logic [FC_W-1:0] FETCH_LAST = FC_W'(FETCH_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SHIFT, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic [LEN_W-1:0]  remaining_q, remaining_d;
   logic [FC_W-1:0]   fetch_cnt_q, fetch_cnt_d;
   logic              xfer;
   logic              kill;

   function automatic logic [DATA_W-1:0] shift_one(input logic [DATA_W-1:0] s);
      if (MSB_FIRST) return s << 1;
      else           return s >> 1;
   endfunction

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= S_IDLE;
         shreg_q     <= '0;
         bit_cnt_q   <= '0;
         remaining_q <= '0;
         fetch_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         shreg_q     <= shreg_d;
         bit_cnt_q   <= bit_cnt_d;
         remaining_q <= remaining_d;
         fetch_cnt_q <= fetch_cnt_d;
      end
   end

   assign kill = abort && (state_q != S_IDLE);
   assign xfer = bit_valid && bit_ready;

   always_comb begin
      state_d = state_q;
      if (kill) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:  if (start) state_d = (tx_len == '0) ? S_DONE : S_FETCH;
            S_FETCH: if (fifo_read_en && fetch_cnt_q == FETCH_LAST) state_d = S_SHIFT;
            S_SHIFT: if (xfer && bit_cnt_q == BIT_LAST)
                        state_d = (remaining_q == LEN_W'(1)) ? S_DONE : S_FETCH;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // A pop, once begun, runs to completion regardless of fifo_empty because read_en ignores the flag then
   always_comb begin
      shreg_d     = shreg_q;
      bit_cnt_d   = bit_cnt_q;
      remaining_d = remaining_q;
      fetch_cnt_d = fetch_cnt_q;
      if (kill) begin
         bit_cnt_d   = '0;
         remaining_d = '0;
         fetch_cnt_d = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start && tx_len != '0) begin
                  remaining_d = tx_len;
                  bit_cnt_d   = '0;
                  fetch_cnt_d = '0;
               end
            end
            S_FETCH: begin
               if (fifo_read_en) begin
                  if (fetch_cnt_q == FETCH_LAST) begin
                     shreg_d     = fifo_data;
                     bit_cnt_d   = '0;
                     fetch_cnt_d = '0;
                  end else begin
                     fetch_cnt_d = fetch_cnt_q + 1'b1;
                  end
               end
            end
            S_SHIFT: begin
               if (xfer) begin
                  shreg_d = shift_one(shreg_q);
                  if (bit_cnt_q == BIT_LAST) begin
                     bit_cnt_d   = '0;
                     remaining_d = remaining_q - 1'b1;
                  end else begin
                     bit_cnt_d = bit_cnt_q + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      fifo_read_en = (state_q == S_FETCH) && (fetch_cnt_q != '0 || !fifo_empty);
      underrun     = (state_q == S_FETCH) && (fetch_cnt_q == '0) && fifo_empty;
      bit_valid    = (state_q == S_SHIFT);
      bit_out      = MSB_FIRST ? shreg_q[DATA_W-1] : shreg_q[0];
      busy         = (state_q != S_IDLE);
      done         = (state_q == S_DONE);
      bytes_left   = remaining_q;
   end

endmodule

// File: tb/tb_fifo_bit_serializer.sv
// Bench for fifo_bit_serializer: a behavioural FIFO feeds the DUT, and a scoreboard of
// expected {bit, bytes_left} pairs is checked on every accepted bit.
module tb_fifo_bit_serializer;
   localparam int DATA_W       = 8;
   localparam int LEN_W        = 6;
   localparam int FETCH_CYCLES = 2;

   logic              clock = 1'b0;
   logic              reset, start, abort, bit_ready;
   logic [LEN_W-1:0]  tx_len;
   logic              fifo_empty, fifo_read_en, bit_out, bit_valid, busy, underrun, done;
   logic [DATA_W-1:0] fifo_data;
   logic [LEN_W-1:0]  bytes_left;

   always #5 clock = ~clock;

   fifo_bit_serializer #(.DATA_W(DATA_W), .LEN_W(LEN_W), .FETCH_CYCLES(FETCH_CYCLES), .MSB_FIRST(1'b1)) dut (
      .clock(clock), .reset(reset), .start(start), .tx_len(tx_len), .abort(abort),
      .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_read_en(fifo_read_en),
      .bit_out(bit_out), .bit_valid(bit_valid), .bit_ready(bit_ready), .busy(busy),
      .underrun(underrun), .done(done), .bytes_left(bytes_left));

   // Behavioural FIFO: data presented at the read pointer, popped after FETCH_CYCLES read strobes
   logic [7:0] mem [256];
   logic [7:0] wr_ptr = 8'd0;
   logic [7:0] rd_ptr = 8'd0;
   int         pop_cnt = 0;
   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_data  = mem[rd_ptr];

   always @(posedge clock) begin
      if (fifo_read_en) begin
         if (pop_cnt == FETCH_CYCLES - 1) begin
            rd_ptr  <= rd_ptr + 8'd1;
            pop_cnt <= 0;
         end else begin
            pop_cnt <= pop_cnt + 1;
         end
      end
   end

   typedef struct packed {
      logic             b;
      logic [LEN_W-1:0] left;
   } exp_t;
   exp_t sb[$];

   int   n_cmp = 0, n_fail = 0, xfer_cnt = 0, rd_cnt = 0;
   logic hold_vld = 1'b0, hold_bit = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clock) begin
      exp_t e;
      if (fifo_read_en) rd_cnt++;
      if (hold_vld) begin
         check("hold_valid", 32'(bit_valid), 32'd1);
         check("hold_bit", 32'(bit_out), 32'(hold_bit));
      end
      if (bit_valid && bit_ready) begin
         xfer_cnt++;
         if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_bit: got bit %0b expected no transfer (t=%0t)", bit_out, $time);
         end else begin
            e = sb.pop_front();
            check("bit_out", 32'(bit_out), 32'(e.b));
            check("bytes_left", 32'(bytes_left), 32'(e.left));
         end
      end
      hold_vld = bit_valid && !bit_ready && !abort && !reset;
      hold_bit = bit_out;
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic push_byte(input logic [7:0] b);
      mem[wr_ptr] = b;
      wr_ptr      = wr_ptr + 8'd1;
   endtask

   task automatic expect_bits(input logic [7:0] b, input int left, input int nbits);
      exp_t e;
      for (int i = 0; i < nbits; i++) begin
         e.b    = b[7-i];
         e.left = LEN_W'(left);
         sb.push_back(e);
      end
   endtask

   function automatic logic rdy(input int mode, input int cyc);
      if (mode == 1) return cyc[0];
      if (mode == 2) return logic'($urandom_range(0, 1));
      return 1'b1;
   endfunction

   task automatic wait_xfers(input int target);
      int budget = 0;
      while (xfer_cnt < target && budget < 300) begin
         step();
         budget++;
      end
      check("xfer_wait_in_budget", 32'(xfer_cnt >= target), 32'd1);
   endtask

   task automatic wait_done(output bit got);
      int budget = 0;
      got = 1'b0;
      while (!got && budget < 300) begin
         @(negedge clock);
         if (done) got = 1'b1;
         else begin
            step();
            budget++;
         end
      end
   endtask

   task automatic run_frame(input int len, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input int mode, input int exp_cyc);
      logic [7:0] bytes [3];
      int         cyc, rd0;
      bit         got;
      bytes[0] = b0;
      bytes[1] = b1;
      bytes[2] = b2;
      for (int k = 0; k < len; k++) begin
         push_byte(bytes[k]);
         expect_bits(bytes[k], len - k, 8);
      end
      rd0    = rd_cnt;
      start  = 1'b1;
      tx_len = LEN_W'(len);
      step();
      start = 1'b0;
      cyc   = 1;
      got   = 1'b0;
      while (!got && cyc < 400) begin
         bit_ready = rdy(mode, cyc);
         @(negedge clock);
         if (done) got = 1'b1;
         else begin
            step();
            cyc++;
         end
      end
      check("done_seen", 32'(got), 32'd1);
      if (exp_cyc >= 0) check("done_cycle", 32'(cyc), 32'(exp_cyc));
      check("busy_at_done", 32'(busy), 32'd1);
      check("bytes_left_at_done", 32'(bytes_left), 32'd0);
      step();
      bit_ready = 1'b0;
      @(negedge clock);
      check("done_one_cycle", 32'(done), 32'd0);
      check("idle_after_done", 32'(busy), 32'd0);
      check("read_en_cycles", 32'(rd_cnt - rd0), 32'(FETCH_CYCLES * len));
      check("sb_drained", 32'(sb.size()), 32'd0);
      step();
   endtask

   typedef struct {
      int         len;
      logic [7:0] b0, b1, b2;
      int         mode;
      int         exp_cyc;
   } vec_t;
   vec_t tbl[6];

   initial begin
      bit got;
      int xb;
      tbl[0] = '{len: 2, b0: 8'hA5, b1: 8'h3C, b2: 8'h00, mode: 0, exp_cyc: 21};
      tbl[1] = '{len: 2, b0: 8'hA5, b1: 8'h3C, b2: 8'h00, mode: 1, exp_cyc: -1};
      tbl[2] = '{len: 0, b0: 8'h00, b1: 8'h00, b2: 8'h00, mode: 0, exp_cyc: 1};
      tbl[3] = '{len: 1, b0: 8'h80, b1: 8'h00, b2: 8'h00, mode: 0, exp_cyc: 11};
      tbl[4] = '{len: 3, b0: 8'h01, b1: 8'hFE, b2: 8'h7E, mode: 2, exp_cyc: -1};
      tbl[5] = '{len: 3, b0: 8'hC3, b1: 8'h0F, b2: 8'h96, mode: 0, exp_cyc: 31};

      reset     = 1'b1;
      start     = 1'b0;
      abort     = 1'b0;
      bit_ready = 1'b0;
      tx_len    = '0;
      step();
      step();
      @(negedge clock);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_valid", 32'(bit_valid), 32'd0);
      check("rst_read_en", 32'(fifo_read_en), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_underrun", 32'(underrun), 32'd0);
      check("rst_bytes_left", 32'(bytes_left), 32'd0);
      check("rst_bit_out", 32'(bit_out), 32'd0);
      step();
      reset = 1'b0;
      step();

      for (int i = 0; i < 6; i++)
         run_frame(tbl[i].len, tbl[i].b0, tbl[i].b1, tbl[i].b2, tbl[i].mode, tbl[i].exp_cyc);

      // Underrun: three-byte frame with the FIFO refilled one byte at a time
      xb = xfer_cnt;
      push_byte(8'hFF);
      expect_bits(8'hFF, 3, 8);
      expect_bits(8'h55, 2, 8);
      expect_bits(8'h00, 1, 8);
      bit_ready = 1'b1;
      start     = 1'b1;
      tx_len    = LEN_W'(3);
      step();
      start = 1'b0;
      wait_xfers(xb + 8);
      @(negedge clock);
      check("ur_underrun", 32'(underrun), 32'd1);
      check("ur_read_en", 32'(fifo_read_en), 32'd0);
      check("ur_valid", 32'(bit_valid), 32'd0);
      check("ur_bytes_left", 32'(bytes_left), 32'd2);
      repeat (3) step();
      @(negedge clock);
      check("ur_still_waiting", 32'(underrun), 32'd1);
      step();
      push_byte(8'h55);
      @(negedge clock);
      check("ur_cleared", 32'(underrun), 32'd0);
      check("ur_read_en_resume", 32'(fifo_read_en), 32'd1);
      wait_xfers(xb + 16);
      @(negedge clock);
      check("ur_second_wait", 32'(underrun), 32'd1);
      check("ur_second_valid", 32'(bit_valid), 32'd0);
      step();
      push_byte(8'h00);
      wait_done(got);
      check("ur_done_seen", 32'(got), 32'd1);
      step();
      check("ur_sb_drained", 32'(sb.size()), 32'd0);

      // Start while busy is ignored; abort mid byte 2 of a 4-byte frame
      xb = xfer_cnt;
      push_byte(8'hA1);
      push_byte(8'h5E);
      expect_bits(8'hA1, 4, 8);
      expect_bits(8'h5E, 3, 3);
      bit_ready = 1'b1;
      start     = 1'b1;
      tx_len    = LEN_W'(4);
      step();
      start = 1'b0;
      wait_xfers(xb + 2);
      start  = 1'b1;
      tx_len = LEN_W'(1);
      step();
      start = 1'b0;
      @(negedge clock);
      check("start_ignored_left", 32'(bytes_left), 32'd4);
      check("start_ignored_busy", 32'(busy), 32'd1);
      wait_xfers(xb + 11);
      abort     = 1'b1;
      bit_ready = 1'b0;
      step();
      abort = 1'b0;
      @(negedge clock);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_valid", 32'(bit_valid), 32'd0);
      check("abort_read_en", 32'(fifo_read_en), 32'd0);
      check("abort_sb_drained", 32'(sb.size()), 32'd0);
      for (int i = 0; i < 4; i++) begin
         check("abort_no_done", 32'(done), 32'd0);
         step();
         @(negedge clock);
      end
      step();
      run_frame(2, 8'h3C, 8'hC3, 8'h00, 0, 21);

      // Reset asserted for one cycle in the middle of a byte
      xb = xfer_cnt;
      push_byte(8'hC3);
      expect_bits(8'hC3, 1, 3);
      bit_ready = 1'b1;
      start     = 1'b1;
      tx_len    = LEN_W'(1);
      step();
      start = 1'b0;
      wait_xfers(xb + 3);
      reset     = 1'b1;
      bit_ready = 1'b0;
      step();
      reset = 1'b0;
      @(negedge clock);
      check("mrst_busy", 32'(busy), 32'd0);
      check("mrst_valid", 32'(bit_valid), 32'd0);
      check("mrst_bit_out", 32'(bit_out), 32'd0);
      check("mrst_bytes_left", 32'(bytes_left), 32'd0);
      check("mrst_done", 32'(done), 32'd0);
      check("mrst_underrun", 32'(underrun), 32'd0);
      check("mrst_read_en", 32'(fifo_read_en), 32'd0);
      check("mrst_sb_drained", 32'(sb.size()), 32'd0);
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
